// File: rtl/cgra_input_stream.sv
// Input-node memory streamer: issues a strided sequence of OBI-style reads and
// buffers the returned words in a small FIFO that feeds one CGRA input node.

package cgra_pkg;
    localparam int FIFO_DEPTH     = 8;
    localparam int FIFO_PTR_WIDTH = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_MAIN_IDLE = 2'd0,
        S_MAIN_EXEC = 2'd1,
        S_MAIN_WAIT = 2'd2,
        S_MAIN_DONE = 2'd3
    } main_fsm_t;
endpackage

module cgra_input_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = cgra_pkg::FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [15:0]           size_i,
    input  logic [15:0]           stride_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);
    import cgra_pkg::main_fsm_t;
    import cgra_pkg::S_MAIN_IDLE;
    import cgra_pkg::S_MAIN_EXEC;
    import cgra_pkg::S_MAIN_WAIT;
    import cgra_pkg::S_MAIN_DONE;

    localparam int FIFO_PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0]          CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]          CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W:0]            CREDIT_LIM = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_PTR_WIDTH-1:0] PTR_ONE    = FIFO_PTR_WIDTH'(1);

    main_fsm_t                 state_q, state_d;
    logic                      busy_q;
    logic                      done_q;
    logic                      req_q, req_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [15:0]               size_q, size_d;
    logic [15:0]               stride_q, stride_d;
    logic [15:0]               issue_q, issue_d;
    logic [CNT_W-1:0]          out_q, out_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [FIFO_PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]     fifo_q [FIFO_DEPTH];

    logic                      grant_s;
    logic                      push_s;
    logic                      pop_s;
    logic [CNT_W:0]            credit_s;

    // Responses outside an active transfer are stale leftovers and must not be buffered.
    assign grant_s = req_q & mem_gnt_i;
    assign push_s  = mem_rvalid_i & ((state_q == S_MAIN_EXEC) | (state_q == S_MAIN_WAIT));
    assign pop_s   = (cnt_q != CNT_ZERO) & ready_i;

    // Main FSM next state, transfer parameters and address accumulator.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        stride_d = stride_q;
        issue_d  = issue_q;
        case (state_q)
            S_MAIN_IDLE: begin
                if (start_i) begin
                    addr_d   = base_addr_i;
                    size_d   = size_i;
                    stride_d = stride_i;
                    issue_d  = 16'd0;
                    if (size_i != 16'd0) begin
                        state_d = S_MAIN_EXEC;
                    end else begin
                        state_d = S_MAIN_DONE;
                    end
                end else begin
                    state_d = S_MAIN_IDLE;
                end
            end
            S_MAIN_EXEC: begin
                if (grant_s) begin
                    addr_d  = addr_q + ADDR_WIDTH'(stride_q);
                    issue_d = issue_q + 16'd1;
                    if ((issue_q + 16'd1) == size_q) begin
                        state_d = S_MAIN_WAIT;
                    end else begin
                        state_d = S_MAIN_EXEC;
                    end
                end else begin
                    state_d = S_MAIN_EXEC;
                end
            end
            S_MAIN_WAIT: begin
                if ((out_q == CNT_ZERO) && (cnt_q == CNT_ZERO)) begin
                    state_d = S_MAIN_DONE;
                end else begin
                    state_d = S_MAIN_WAIT;
                end
            end
            S_MAIN_DONE: begin
                state_d = S_MAIN_IDLE;
            end
            default: begin
                state_d = S_MAIN_IDLE;
            end
        endcase
    end

    // Outstanding-request and FIFO occupancy bookkeeping.
    always_comb begin
        out_d    = out_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (grant_s && !push_s) begin
            out_d = out_q + CNT_ONE;
        end else if (!grant_s && push_s) begin
            out_d = out_q - CNT_ONE;
        end else begin
            out_d = out_q;
        end
        if (push_s && !pop_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!push_s && pop_s) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Every in-flight request owns a FIFO slot, so an rvalid can never find the FIFO full.
    always_comb begin
        credit_s = {1'b0, out_d} + {1'b0, cnt_d};
        if (req_q && !mem_gnt_i && (state_q == S_MAIN_EXEC)) begin
            req_d = 1'b1;
        end else if ((state_d == S_MAIN_EXEC) && (issue_d < size_d) && (credit_s < CREDIT_LIM)) begin
            req_d = 1'b1;
        end else begin
            req_d = 1'b0;
        end
    end

    // Control registers and registered status/request outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_MAIN_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= {ADDR_WIDTH{1'b0}};
            size_q   <= 16'd0;
            stride_q <= 16'd0;
            issue_q  <= 16'd0;
            out_q    <= CNT_ZERO;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d != S_MAIN_IDLE);
            done_q   <= (state_d == S_MAIN_DONE);
            req_q    <= req_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            stride_q <= stride_d;
            issue_q  <= issue_d;
            out_q    <= out_d;
        end
    end

    // FIFO storage and pointers; storage is cleared so data_o reads zero out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_q <= {FIFO_PTR_WIDTH{1'b0}};
            rd_ptr_q <= {FIFO_PTR_WIDTH{1'b0}};
            cnt_q    <= CNT_ZERO;
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= mem_rdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign valid_o    = (cnt_q != CNT_ZERO);
    assign data_o     = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_cgra_input_stream.sv
// Scoreboard bench for cgra_input_stream: a reactive memory/sink agent checks
// grants and delivered words against queues filled when each start is issued.

module tb_cgra_input_stream;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] size_i;
    logic [15:0] stride_i;
    logic        busy_o;
    logic        done_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    rsp_t        rsp_q[$];

    int tests_run  = 0;
    int fails      = 0;
    int cyc        = 0;
    int grant_cnt  = 0;
    int done_cnt   = 0;
    int done_base  = 0;
    int lat        = 1;
    int max_stall  = 0;
    int ready_mode = 1;
    int stall_left = -1;

    cgra_input_stream dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .size_i      (size_i),
        .stride_i    (stride_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // Memory and stream-sink agent: drives gnt/rvalid/ready between clock edges.
    initial begin : agent
        logic        prev_pend;
        logic [31:0] prev_addr;
        logic [31:0] ea;
        logic [31:0] ed;
        rsp_t        r;
        prev_pend    = 1'b0;
        prev_addr    = 32'd0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        ready_i      = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_pend && !rst_i) begin
                tests_run++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== prev_addr) begin
                    fails++;
                    $display("FAIL req_hold: req=%0b addr=%h, required req=1 addr=%h", mem_req_o, mem_addr_o, prev_addr);
                end
            end
            if (done_o === 1'b1) done_cnt++;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                r            = rsp_q.pop_front();
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = r.data;
            end else begin
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = 32'd0;
            end
            mem_gnt_i = 1'b0;
            if (mem_req_o === 1'b1 && !rst_i) begin
                if (stall_left < 0) stall_left = int'($urandom_range(max_stall, 0));
                if (stall_left == 0) begin
                    mem_gnt_i  = 1'b1;
                    stall_left = -1;
                    grant_cnt++;
                    tests_run++;
                    if (exp_addr_q.size() == 0) begin
                        fails++;
                        $display("FAIL grant_addr: unexpected grant at addr %h, required no request", mem_addr_o);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        if (mem_addr_o !== ea) begin
                            fails++;
                            $display("FAIL grant_addr: got %h, required %h", mem_addr_o, ea);
                        end
                    end
                    r.due  = cyc + lat;
                    r.data = mem_fn(mem_addr_o);
                    rsp_q.push_back(r);
                    tests_run++;
                    if (rsp_q.size() > DEPTH) begin
                        fails++;
                        $display("FAIL outstanding: got %0d in flight, required <= %0d", rsp_q.size(), DEPTH);
                    end
                end else begin
                    stall_left--;
                end
            end
            prev_pend = (mem_req_o === 1'b1) && !mem_gnt_i && !rst_i;
            prev_addr = mem_addr_o;
            if (ready_mode == 1)      ready_i = 1'b1;
            else if (ready_mode == 2) ready_i = ($urandom_range(1, 0) == 32'd1);
            else                      ready_i = 1'b0;
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                tests_run++;
                if (exp_data_q.size() == 0) begin
                    fails++;
                    $display("FAIL stream_data: unexpected word %h, required none", data_o);
                end else begin
                    ed = exp_data_q.pop_front();
                    if (data_o !== ed) begin
                        fails++;
                        $display("FAIL stream_data: got %h, required %h", data_o, ed);
                    end
                end
            end
        end
    end

    task automatic kick(input logic [31:0] base, input logic [15:0] size, input logic [15:0] stride);
        logic [31:0] a;
        for (int n = 0; n < int'(size); n++) begin
            a = base + 32'(n) * {16'h0000, stride};
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem_fn(a));
        end
        @(negedge clk); #1;
        done_base   = done_cnt;
        start_i     = 1'b1;
        base_addr_i = base;
        size_i      = size;
        stride_i    = stride;
        @(negedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        tests_run++;
        if (done_cnt == done_base) begin
            fails++;
            $display("FAIL %s_timeout: no done_o within %0d cycles", name, budget);
        end
        repeat (6) @(negedge clk);
        #1;
        tests_run++;
        if (done_cnt !== done_base + 1) begin
            fails++;
            $display("FAIL %s_done_count: got %0d pulses, required 1", name, done_cnt - done_base);
        end
        tests_run++;
        if (exp_addr_q.size() != 0 || exp_data_q.size() != 0) begin
            fails++;
            $display("FAIL %s_leftover: %0d addrs %0d words pending, required 0", name, exp_addr_q.size(), exp_data_q.size());
        end
        tests_run++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: busy_o=%0b, required 0", name, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({busy_o, done_o, mem_req_o, valid_o} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: busy/done/req/valid=%b, required 0000", {busy_o, done_o, mem_req_o, valid_o});
        end
        tests_run++;
        if (mem_addr_o !== 32'd0 || data_o !== 32'd0) begin
            fails++;
            $display("FAIL reset_data: addr=%h data=%h, required 0 and 0", mem_addr_o, data_o);
        end
        rst_i = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_streaming();
        lat = 1; max_stall = 0; ready_mode = 1;
        kick(32'h0000_1000, 16'd4, 16'd4);
        wait_done("streaming", 200);
    endtask

    task automatic test_back_pressure();
        int g0;
        lat = 1; max_stall = 0; ready_mode = 0;
        g0 = grant_cnt;
        kick(32'h0000_8000, 16'd20, 16'd8);
        repeat (30) @(negedge clk);
        #1;
        tests_run++;
        if (grant_cnt - g0 != DEPTH) begin
            fails++;
            $display("FAIL bp_grants: got %0d, required %0d", grant_cnt - g0, DEPTH);
        end
        tests_run++;
        if (mem_req_o !== 1'b0 || valid_o !== 1'b1 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL bp_stall: req=%0b valid=%0b busy=%0b, required 0 1 1", mem_req_o, valid_o, busy_o);
        end
        tests_run++;
        if (data_o !== exp_data_q[0]) begin
            fails++;
            $display("FAIL bp_head: got %h, required %h", data_o, exp_data_q[0]);
        end
        ready_mode = 1;
        wait_done("back_pressure", 400);
    endtask

    task automatic test_latency();
        lat = 4; max_stall = 3; ready_mode = 2;
        kick(32'h2000_0000, 16'd30, 16'd12);
        wait_done("latency", 2000);
        ready_mode = 1;
    endtask

    task automatic test_size_zero();
        int g0;
        lat = 1; max_stall = 0; ready_mode = 1;
        g0 = grant_cnt;
        kick(32'h0000_7000, 16'd0, 16'd4);
        tests_run++;
        if (done_o !== 1'b1 || mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL size0_done: done=%0b req=%0b busy=%0b, required 1 0 1", done_o, mem_req_o, busy_o);
        end
        wait_done("size0", 20);
        tests_run++;
        if (grant_cnt != g0) begin
            fails++;
            $display("FAIL size0_grants: got %0d, required 0", grant_cnt - g0);
        end
    endtask

    task automatic test_addr_wrap();
        lat = 1; max_stall = 1; ready_mode = 1;
        kick(32'hFFFF_FFF8, 16'd4, 16'd4);
        wait_done("wrap", 200);
    endtask

    task automatic test_reset_mid_exec();
        int g0;
        int n;
        lat = 4; max_stall = 0; ready_mode = 1;
        g0 = grant_cnt;
        kick(32'h0000_3000, 16'd10, 16'd4);
        n = 0;
        while (grant_cnt - g0 < 3 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        tests_run++;
        if (grant_cnt - g0 < 3) begin
            fails++;
            $display("FAIL rst_mid_grants: got %0d, required 3", grant_cnt - g0);
        end
        rst_i = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        stall_left = -1;
        repeat (2) @(negedge clk);
        #1;
        rst_i = 1'b0;
        n = 0;
        while (rsp_q.size() > 0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_stale: valid=%0b busy=%0b req=%0b, required 0 0 0", valid_o, busy_o, mem_req_o);
        end
        lat = 1;
        kick(32'h0000_4000, 16'd2, 16'd4);
        wait_done("rst_mid", 200);
    endtask

    task automatic test_ignored_start();
        int n;
        lat = 4; max_stall = 1; ready_mode = 1;
        kick(32'h0000_5000, 16'd6, 16'd4);
        n = 0;
        while (done_cnt == done_base && n < 300) begin
            if (busy_o === 1'b1 && done_o !== 1'b1) begin
                start_i     = 1'b1;
                base_addr_i = 32'hDEAD_0000;
                size_i      = 16'd3;
                stride_i    = 16'd16;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk); #1;
            n++;
        end
        start_i = 1'b0;
        wait_done("ignored_start", 50);
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        base_addr_i = 32'd0;
        size_i      = 16'd0;
        stride_i    = 16'd0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_latency();
        test_size_zero();
        test_addr_wrap();
        test_reset_mid_exec();
        test_ignored_start();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
